// File: rtl/wide_add_pkg.sv
// Shared constants, state encoding and sizing helper for the wide add/subtract sequencer.
package wide_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index register width; never below 1 bit so the index stays a real vector.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla16_slice.sv
// Purely combinational 16-bit two-level carry-lookahead adder (four 4-bit groups).
module cla16_slice (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;
  logic [3:0]  gg_s;
  logic [3:0]  pg_s;
  logic [4:0]  cg_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Group-level carries are expanded directly from group G/P and cin, not rippled.
  assign cg_s[0] = cin;
  assign cg_s[1] = gg_s[0] | (pg_s[0] & cin);
  assign cg_s[2] = gg_s[1] | (pg_s[1] & gg_s[0]) | (pg_s[1] & pg_s[0] & cin);
  assign cg_s[3] = gg_s[2] | (pg_s[2] & gg_s[1]) | (pg_s[2] & pg_s[1] & gg_s[0])
                 | (pg_s[2] & pg_s[1] & pg_s[0] & cin);
  assign cg_s[4] = gg_s[3] | (pg_s[3] & gg_s[2]) | (pg_s[3] & pg_s[2] & gg_s[1])
                 | (pg_s[3] & pg_s[2] & pg_s[1] & gg_s[0])
                 | (pg_s[3] & pg_s[2] & pg_s[1] & pg_s[0] & cin);

  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B = 4 * j;

    assign gg_s[j] = g_s[B+3] | (p_s[B+3] & g_s[B+2]) | (p_s[B+3] & p_s[B+2] & g_s[B+1])
                   | (p_s[B+3] & p_s[B+2] & p_s[B+1] & g_s[B]);
    assign pg_s[j] = &p_s[B+3:B];

    assign c_s[B]   = cg_s[j];
    assign c_s[B+1] = g_s[B] | (p_s[B] & cg_s[j]);
    assign c_s[B+2] = g_s[B+1] | (p_s[B+1] & g_s[B]) | (p_s[B+1] & p_s[B] & cg_s[j]);
    assign c_s[B+3] = g_s[B+2] | (p_s[B+2] & g_s[B+1]) | (p_s[B+2] & p_s[B+1] & g_s[B])
                    | (p_s[B+2] & p_s[B+1] & p_s[B] & cg_s[j]);
  end

  assign sum  = p_s ^ c_s;
  assign cout = cg_s[4];

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS*16-bit add/subtract computed one 16-bit word per cycle on a shared CLA slice.
// Optional sticky zero-result flag on out_zero when WIDE_ADD_ZERO_FLAG_EN is defined.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int W     = WORD_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf
`ifdef WIDE_ADD_ZERO_FLAG_EN
  ,
  output logic         out_zero
`endif
);

  localparam int             IW       = idx_width(WORDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WORDS - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IW-1:0]       idx_r;
  logic                carry_r;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        sum_r;
  logic                cout_r;
  logic                ovf_r;
  logic [WORD_W-1:0]   slice_a_s;
  logic [WORD_W-1:0]   slice_b_s;
  logic [WORD_W-1:0]   slice_sum_s;
  logic                slice_cout_s;
  logic                accept_s;
  logic                last_s;

  assign accept_s  = (state_r == IDLE) && in_valid;
  assign last_s    = (idx_r == LAST_IDX);
  assign slice_a_s = a_r[int'(idx_r) * WORD_W +: WORD_W];
  assign slice_b_s = b_r[int'(idx_r) * WORD_W +: WORD_W];

  cla16_slice u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)  state_nxt_s = RUN;  else state_nxt_s = IDLE;
      RUN:     if (last_s)    state_nxt_s = DONE; else state_nxt_s = RUN;
      DONE:    if (out_ready) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, per-word accumulation and final flag registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= in_a;
            b_r     <= in_sub ? ~in_b : in_b;
            carry_r <= in_sub ? 1'b1 : in_cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          sum_r[int'(idx_r) * WORD_W +: WORD_W] <= slice_sum_s;
          carry_r <= slice_cout_s;
          if (last_s) begin
            cout_r <= slice_cout_s;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_sum_s[WORD_W-1] != a_r[W-1]);
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef WIDE_ADD_ZERO_FLAG_EN
  logic zero_acc_r;
  logic zero_r;

  // Sticky all-zero tracking; the last word folds in directly so out_zero lands with out_cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc_r <= 1'b0;
      zero_r     <= 1'b0;
    end else if (accept_s) begin
      zero_acc_r <= 1'b1;
    end else if (state_r == RUN) begin
      zero_acc_r <= zero_acc_r & (slice_sum_s == 16'h0000);
      if (last_s) begin
        zero_r <= zero_acc_r & (slice_sum_s == 16'h0000);
      end
    end
  end

  assign out_zero = zero_r;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed, table-driven bench for wide_add_sequencer (WORDS=4); zero-flag checks run when WIDE_ADD_ZERO_FLAG_EN is defined.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
`ifdef WIDE_ADD_ZERO_FLAG_EN
  logic         out_zero;
`endif

  int nvec  = 0;
  int nfail = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
`ifdef WIDE_ADD_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at a negedge: present the op, wait for acceptance, then check latency and result.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf);
    int n;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, " accept"}, W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, W'(n), W'(WORDS));
    check({name, " sum"}, out_sum, esum);
    check({name, " cout"}, W'(out_cout), W'(ecout));
    check({name, " ovf"}, W'(out_ovf), W'(eovf));
  endtask

  task automatic finish_op(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " valid drop"}, W'(out_valid), W'(0));
    check({name, " ready back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"add_wrap",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{"sub_neg",    64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{"add_ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{"add_cin",    64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[4] = '{"sub_ovf",    64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{"sub_cinign", 64'h10, 64'h10, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[6] = '{"add_negovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[7] = '{"add_mix",    64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst out_sum", out_sum, W'(0));
    check("rst out_cout", W'(out_cout), W'(0));
    check("rst out_ovf", W'(out_ovf), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      finish_op(vecs[i].name);
    end

    // Backpressure: result must hold and the queued op must wait for the handshake.
    run_op("bp_first", 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0, 1'b0,
           64'h0000_0004_0000_0006, 1'b0, 1'b0);
    in_a = 64'h0000_0000_0000_0100; in_b = 64'h0000_0000_0000_0001;
    in_cin = 1'b0; in_sub = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp hold sum", out_sum, 64'h0000_0004_0000_0006);
      check("bp in_ready", W'(in_ready), W'(0));
      check("bp out_valid", W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp ready after hs", W'(in_ready), W'(1));
    run_op("bp_second", 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b0, 1'b1,
           64'h0000_0000_0000_00FF, 1'b1, 1'b0);
    finish_op("bp_second");

    // Reset on the second RUN cycle drops the op and clears the result.
    in_a = 64'h1111_2222_3333_4444; in_b = 64'h1; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", W'(out_valid), W'(0));
    check("midrst in_ready", W'(in_ready), W'(1));
    check("midrst out_sum", out_sum, W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst dropped", W'(out_valid), W'(0));
    run_op("post_rst", 64'h0001_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0001_0000_0001_0000, 1'b0, 1'b0);
    finish_op("post_rst");

`ifdef WIDE_ADD_ZERO_FLAG_EN
    run_op("zero_sub", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1,
           64'h0, 1'b1, 1'b0);
    check("zero_sub flag", W'(out_zero), W'(1));
    finish_op("zero_sub");
    run_op("zero_add", 64'h1, 64'h0, 1'b0, 1'b0, 64'h1, 1'b0, 1'b0);
    check("zero_add flag", W'(out_zero), W'(0));
    finish_op("zero_add");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
